// File: rtl/dma_ctrl_nch.sv
// dma_ctrl_nch -- N-channel fly-by DMA controller (8237-style, single-mode transfers).
//
// Arbitrates the per-channel DREQ lines, requests the bus with HRQ/HLDA and runs one
// four-state memory<->I/O cycle (S1..S4) per grant. The cycle uses the channel's current
// address and count registers. Terminal count, external EOP and auto-initialise are
// supported.
//
// Build option:
//   ROT_PRIO_EN  defined   -> rotating priority. The channel served last becomes the
//                             lowest priority.
//                undefined -> fixed priority. Channel 0 is the highest.
//
// Ports:
//   CLK, RESET_n          clock (rising edge), asynchronous active-low reset
//   reg_cs/reg_we         register select / write strobe
//   reg_addr              {channel, offset[1:0]}
//                           offset 0 = address, 1 = count, 2 = mode, 3 = status
//   reg_wdata/reg_rdata   register write data / combinational read data
//   DREQ/DACK             per-channel request / one-hot acknowledge
//   HRQ/HLDA              hold request / hold acknowledge
//   AEN, ADSTB, ADDR      address enable, address strobe, transfer address
//   MEMR_n/MEMW_n         memory read / write strobes, active low
//   IOR_n/IOW_n           I/O read / write strobes, active low
//   EOP_ni/EOP_no         external end-of-process in / terminal-count pulse out
module dma_ctrl_nch #(
    parameter int NCH = 4,
    parameter int AW  = 16,
    parameter int CW  = 16
) (
    input  logic                     CLK,
    input  logic                     RESET_n,
    input  logic                     reg_cs,
    input  logic                     reg_we,
    input  logic [$clog2(NCH)+1:0]   reg_addr,
    input  logic [AW-1:0]            reg_wdata,
    output logic [AW-1:0]            reg_rdata,
    input  logic [NCH-1:0]           DREQ,
    output logic [NCH-1:0]           DACK,
    output logic                     HRQ,
    input  logic                     HLDA,
    output logic                     AEN,
    output logic                     ADSTB,
    output logic [AW-1:0]            ADDR,
    output logic                     MEMR_n,
    output logic                     MEMW_n,
    output logic                     IOR_n,
    output logic                     IOW_n,
    input  logic                     EOP_ni,
    output logic                     EOP_no
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HOLD = 3'd1;
    localparam logic [2:0] S_S1   = 3'd2;
    localparam logic [2:0] S_S2   = 3'd3;
    localparam logic [2:0] S_S3   = 3'd4;
    localparam logic [2:0] S_S4   = 3'd5;

    logic [AW-1:0]  base_addr [NCH];
    logic [AW-1:0]  cur_addr  [NCH];
    logic [CW-1:0]  base_cnt  [NCH];
    logic [CW-1:0]  cur_cnt   [NCH];
    logic [1:0]     mode      [NCH];
    logic [NCH-1:0] mask;
    logic [NCH-1:0] tc;

    logic [2:0]     state;
    logic [CHW-1:0] ch;
    logic [CHW-1:0] pend;
    logic [CHW-1:0] win;
    logic           found;
    logic           eop_seen;
    logic [NCH-1:0] req;
    logic [CHW-1:0] reg_ch;
    logic [1:0]     reg_off;
    logic           reg_wr;
    logic           active;
    logic           tc_now;

`ifdef ROT_PRIO_EN
    logic [CHW-1:0] ptr;
`endif

    generate
        if (NCH > 1) begin : g_multi
            assign reg_ch = reg_addr[$clog2(NCH)+1:2];
        end else begin : g_single
            assign reg_ch = '0;
        end
    endgenerate

    assign reg_off = reg_addr[1:0];
    assign reg_wr  = reg_cs & reg_we;
    assign req     = DREQ & ~mask;

    // Priority search.
    // In rotating mode the search starts at ptr; in fixed mode it starts at channel 0.
    always_comb begin
        int idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
`ifdef ROT_PRIO_EN
            idx = int'(ptr) + i;
            if (idx >= NCH) idx = idx - NCH;
`else
            idx = i;
`endif
            if (!found && req[idx]) begin
                win   = CHW'(idx);
                found = 1'b1;
            end
        end
    end

    // Terminal count: the count was already zero before this decrement, or EOP arrived.
    assign tc_now = (cur_cnt[ch] == '0) || eop_seen;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state    <= S_IDLE;
            ch       <= '0;
            pend     <= '0;
            eop_seen <= 1'b0;
`ifdef ROT_PRIO_EN
            ptr      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (|req) begin
                    pend  <= win;
                    state <= S_HOLD;
                end
                // Re-arbitrate when HLDA arrives.
                // If every request has dropped meanwhile, serve the channel that raised HRQ.
                S_HOLD: if (HLDA) begin
                    ch    <= found ? win : pend;
                    state <= S_S1;
                end
                S_S1: begin
                    eop_seen <= 1'b0;
                    state    <= S_S2;
                end
                S_S2: begin
                    if (!EOP_ni) eop_seen <= 1'b1;
                    state <= S_S3;
                end
                S_S3: begin
                    if (!EOP_ni) eop_seen <= 1'b1;
                    state <= S_S4;
                end
                S_S4: begin
`ifdef ROT_PRIO_EN
                    ptr <= (int'(ch) == NCH - 1) ? '0 : ch + 1'b1;
`endif
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Channel registers.
    // The register write is placed after the S4 update, so it takes precedence
    // on a same-cycle collision.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            for (int c = 0; c < NCH; c++) begin
                base_addr[c] <= '0;
                cur_addr[c]  <= '0;
                base_cnt[c]  <= '0;
                cur_cnt[c]   <= '0;
                mode[c]      <= '0;
            end
            mask <= '1;
            tc   <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (state == S_S4 && ch == CHW'(c)) begin
                    if (tc_now) begin
                        tc[c] <= 1'b1;
                    end
                    if (tc_now && mode[c][1]) begin
                        cur_addr[c] <= base_addr[c];
                        cur_cnt[c]  <= base_cnt[c];
                    end else begin
                        cur_addr[c] <= cur_addr[c] + 1'b1;
                        cur_cnt[c]  <= cur_cnt[c] - 1'b1;
                        if (tc_now) mask[c] <= 1'b1;
                    end
                end
                if (reg_wr && reg_ch == CHW'(c)) begin
                    case (reg_off)
                        2'd0: begin
                            base_addr[c] <= reg_wdata;
                            cur_addr[c]  <= reg_wdata;
                        end
                        2'd1: begin
                            base_cnt[c] <= reg_wdata[CW-1:0];
                            cur_cnt[c]  <= reg_wdata[CW-1:0];
                        end
                        2'd2: mode[c] <= reg_wdata[1:0];
                        default: begin
                            mask[c] <= reg_wdata[0];
                            if (reg_wdata[1]) tc[c] <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    always_comb begin
        reg_rdata = '0;
        case (reg_off)
            2'd0:    reg_rdata = cur_addr[reg_ch];
            2'd1:    reg_rdata = AW'(cur_cnt[reg_ch]);
            2'd2:    reg_rdata = AW'(mode[reg_ch]);
            default: reg_rdata = AW'({DREQ[reg_ch], tc[reg_ch], mask[reg_ch]});
        endcase
    end

    // Bus outputs are decoded from the state register.
    // An asynchronous reset therefore returns them to idle immediately.
    assign active = (state == S_S1) || (state == S_S2) || (state == S_S3) || (state == S_S4);
    assign HRQ    = (state != S_IDLE);
    assign AEN    = active;
    assign ADSTB  = (state == S_S1);
    assign ADDR   = active ? cur_addr[ch] : '0;
    assign DACK   = active ? (NCH'(1) << ch) : '0;

    // Direction bit: 0 = memory -> I/O (MEMR + IOW), 1 = I/O -> memory (IOR + MEMW).
    assign MEMR_n = ~(((state == S_S2) || (state == S_S3)) && !mode[ch][0]);
    assign IOR_n  = ~(((state == S_S2) || (state == S_S3)) &&  mode[ch][0]);
    assign IOW_n  = ~((state == S_S3) && !mode[ch][0]);
    assign MEMW_n = ~((state == S_S3) &&  mode[ch][0]);
    assign EOP_no = ~((state == S_S4) && tc_now);

endmodule
